proc_fetch_seq: RTL
===================

// Module: proc_fetch_seq
// PURPOSE
//  Instruction sequencer for the 16-bit bus processor: fetches words from a 1-cycle sync ROM, drives the proc's DIN/Run, waits on Done.
//  Feeds the opcode word during proc step T0, and the immediate word during T1 when the opcode is mvi (001).
//  Sits between program ROM and proc. Owns PC, halt detection and a Done watchdog.
// PARAMETERS
//  AW        5    ROM address / PC width; PC wraps modulo 2**AW
//  WD_MAX    7    max cycles in WAIT without Done before Fault (>=3)
// PORTS
//  Clock     in   1    sole clock, rising edge
//  Reset     in   1    synchronous, active-high
//  Start     in   1    1-cycle pulse; IDLE/HALTED/FAULT -> FETCH, PC<=0
//  StopReq   in   1    level; stop after current instruction completes
//  MemAddr   out  AW   ROM read address (data returns next cycle)
//  MemData   in   16   ROM read data
//  DIN       out  16   to proc DIN
//  Run       out  1    to proc Run
//  Done      in   1    from proc Done (combinational in proc's final step)
//  PC        out  AW   address of instruction currently executing/next to fetch
//  Busy      out  1    1 in FETCH/ISSUE/IMM/WAIT
//  Halted    out  1    1 in HALTED
//  Fault     out  1    1 in FAULT (sticky until Reset or Start)
// BEHAVIOUR
//  Reset: state=IDLE, PC=0, MemAddr=0, DIN=0, Run=0, Busy=Halted=Fault=0, wd=0.
//  States: IDLE, FETCH, ISSUE, IMM, WAIT, HALTED, FAULT.
//  FETCH: MemAddr=PC, Run=0 -> ISSUE.
//  ISSUE: DIN=MemData (comb pass), MemAddr=PC+1.
//   - MemData[15:13]==3'b111 (HALT): Run=0, -> HALTED, PC unchanged.
//   - else Run=1; proc latches IR at this edge.
//   - Opcode 001 -> IMM; else -> WAIT.
//  IMM: DIN=MemData (word at PC+1), Run=1.
//   - Done expected this cycle -> PC<=PC+2, -> FETCH/HALTED.
//   - No Done -> FAULT.
//  WAIT: Run=1, DIN=instr word held from ISSUE, wd increments.
//   - Done -> PC<=PC+1, wd<=0, -> FETCH (or HALTED if StopReq).
//   - wd==WD_MAX without Done -> FAULT.
//  Latency: mv = 3 cycles; mvi = 3 cycles; add/sub = 5 cycles (FETCH, ISSUE, WAIT x3).
//  Run=0 in every state other than ISSUE (non-HALT), IMM and WAIT.
//   - Guarantees proc Tstep sits at 0 between instructions.
//  PC arithmetic: modulo 2**AW.
//   - mvi at address 2**AW-1 reads its immediate from address 0; next PC = 1.
//  StopReq is sampled only on the Done cycle.
//   - A halted sequence resumes only via Start (PC<=0).
//  Start while Busy: ignored. Start and Done in the same cycle: Done handling wins.
//  Reset mid-instruction: returns to IDLE next edge with Run=0.
//   - Proc is reset by the system, not by this block.
//  FAULT: Run=0, DIN=0; the proc step counter may be left non-zero.
//   - System must pulse proc Resetn.
// CONFIGURATION
//  PROC_SINGLE_STEP_EN defined:
//   - Adds input Step (1-cycle pulse) and state PAUSE.
//   - After each Done, go to PAUSE (Run=0, Busy=1) instead of FETCH; Step -> FETCH.
//   - StopReq in PAUSE -> HALTED.
//  Undefined: no Step port, no PAUSE; back-to-back execution as above.
// STRUCTURE
//  proc_pkg:
//   - state encoding localparams (3 bits)
//   - opcode localparams OP_MV=000, OP_MVI=001, OP_ADD=010, OP_SUB=011, OP_HALT=111
//   - opcode field slice [15:13]
//  One sub-module: proc_wdog (clear/enable up-counter with terminal-count flag at WD_MAX).
//  Remainder: state register + next-state/output always block in this file.
// TESTING
//  ROM{0:mvi R0 (0x2000), 1:0x0005, 2:HALT 0xE000}, Start ->
//   - DIN=0x2000 with Run=1, then DIN=0x0005 next cycle; Halted=1; PC=2.
//  ROM{0:add R0,R1 (0x4008), 1:HALT}, proc Done at 3rd WAIT cycle ->
//   - Run high exactly 4 cycles (ISSUE + 3 WAIT); PC=1; Halted.
//  Done held 0 in WAIT ->
//   - Fault=1 after WD_MAX+1 WAIT cycles; Run=0; Start clears Fault, PC=0.
//  AW=2, mvi at addr 3 ->
//   - MemAddr sequence 3,0 (wrap); next FETCH at PC=1.
//  StopReq=1 during a multi-cycle add ->
//   - Instruction completes (Done seen), then Halted=1, no further FETCH.
//  Reset asserted in WAIT ->
//   - next cycle IDLE, Run=0, PC=0, Busy=0. With PROC_SINGLE_STEP_EN: PAUSE after each Done until Step.

Source files
------------

// File: rtl/proc_fetch_seq_pkg.sv
// Shared types and constants for the proc fetch sequencer.
// The PAUSE encoding is used only when PROC_SINGLE_STEP_EN is defined.
package proc_fetch_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StIssue  = 3'd2,
    StImm    = 3'd3,
    StWait   = 3'd4,
    StHalted = 3'd5,
    StFault  = 3'd6,
    StPause  = 3'd7
  } state_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 13;

  // Opcode field of a 16-bit instruction word.
  function automatic logic [2:0] opcode_of(input logic [15:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/proc_fetch_seq_wdog.sv
// Done watchdog: clearable up-counter that stops at WdMax and flags terminal count.
module proc_fetch_seq_wdog #(
  parameter int unsigned WdMax = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(WdMax + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CntW'(WdMax));

  // Next count: clear wins, otherwise count up and hold at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/proc_fetch_seq.sv
// Instruction sequencer between a 1-cycle sync program ROM and the bus processor.
// Owns the PC, HALT detection and a Done watchdog.
// Optional feature macro: PROC_SINGLE_STEP_EN adds step_i and a PAUSE state after each Done.
module proc_fetch_seq
  import proc_fetch_seq_pkg::*;
#(
  parameter int unsigned AW     = 5,
  parameter int unsigned WD_MAX = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stop_req_i,
`ifdef PROC_SINGLE_STEP_EN
  input  logic          step_i,
`endif
  output logic [AW-1:0] mem_addr_o,
  input  logic [15:0]   mem_data_i,
  output logic [15:0]   din_o,
  output logic          run_o,
  input  logic          done_i,
  output logic [AW-1:0] pc_o,
  output logic          busy_o,
  output logic          halted_o,
  output logic          fault_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic          wd_clr, wd_en, wd_tc;
  state_e        after_done;
  logic [2:0]    op;

  proc_fetch_seq_wdog #(
    .WdMax (WD_MAX)
  ) u_wdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  assign op = opcode_of(mem_data_i);

  // Where to go once the proc reports Done; StopReq is only honoured here.
  always_comb begin
    after_done = StFetch;
`ifdef PROC_SINGLE_STEP_EN
    after_done = StPause;
`endif
    if (stop_req_i) begin
      after_done = StHalted;
    end
  end

  // Next-state, PC update and proc/ROM outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    mem_addr_o = pc_q;
    din_o      = '0;
    run_o      = 1'b0;
    wd_clr     = 1'b1;
    wd_en      = 1'b0;
    unique case (state_q)
      StIdle, StHalted, StFault: begin
        if (start_i) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        state_d = StIssue;
      end
      StIssue: begin
        // Prefetch the possible immediate while the opcode is on DIN.
        mem_addr_o = pc_q + AW'(1);
        din_o      = mem_data_i;
        ir_d       = mem_data_i;
        if (op == OP_HALT) begin
          state_d = StHalted;
        end else begin
          run_o   = 1'b1;
          state_d = (op == OP_MVI) ? StImm : StWait;
        end
      end
      StImm: begin
        din_o = mem_data_i;
        run_o = 1'b1;
        if (done_i) begin
          pc_d    = pc_q + AW'(2);
          state_d = after_done;
        end else begin
          state_d = StFault;
        end
      end
      StWait: begin
        din_o  = ir_q;
        run_o  = 1'b1;
        wd_clr = 1'b0;
        wd_en  = 1'b1;
        if (done_i) begin
          pc_d    = pc_q + AW'(1);
          wd_clr  = 1'b1;
          state_d = after_done;
        end else if (wd_tc) begin
          state_d = StFault;
        end
      end
`ifdef PROC_SINGLE_STEP_EN
      StPause: begin
        if (stop_req_i) begin
          state_d = StHalted;
        end else if (step_i) begin
          state_d = StFetch;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, PC and held instruction word with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign pc_o     = pc_q;
  assign halted_o = (state_q == StHalted);
  assign fault_o  = (state_q == StFault);
  assign busy_o   = (state_q == StFetch) || (state_q == StIssue) || (state_q == StImm) ||
                    (state_q == StWait)  || (state_q == StPause);

endmodule
